// File: rtl/i2c_bus_frontend.sv
// I2C pin conditioning: synchronise and glitch-filter SCL/SDA, decode START/STOP/edges, track bus busy.
// Optional SCL-low timeout in BUSY is built only when I2C_TIMEOUT_EN is defined.
module i2c_bus_frontend #(
   parameter int SYNC_STAGES     = 2,
   parameter int FILT_LEN        = 3,
   parameter int BUS_FREE_CYCLES = 8,
   parameter int TIMEOUT_CYCLES  = 4096
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_o,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic rstart_o,
   output logic stop_o,
   output logic bus_busy_o,
   output logic timeout_o
);

   localparam int FCW = $clog2(FILT_LEN + 1);
   localparam int BCW = $clog2(BUS_FREE_CYCLES + 1);

   typedef enum logic [1:0] {UNSYNC, IDLE, BUSY, FREE_WAIT} state_t;

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_LEN < 1 || FILT_LEN > 15 ||
       BUS_FREE_CYCLES < 1 || BUS_FREE_CYCLES > 65535 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("i2c_bus_frontend: parameter out of legal range");
   end

   // Bit 0 carries SCL, bit 1 carries SDA throughout.
   logic [1:0] w_pin;
   logic [1:0] w_filt;
   logic [1:0] r_filt_d;

   assign w_pin = {sda_i, scl_i};

   for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] r_sync;
      logic [FCW-1:0]         r_cnt;
      logic                   r_level;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
         end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin[gi]};
            if (r_cnt == FCW'(FILT_LEN)) begin
               r_level <= ~r_level;
               r_cnt   <= '0;
            end else if (r_sync[SYNC_STAGES-1] != r_level) begin
               r_cnt <= r_cnt + FCW'(1);
            end else begin
               r_cnt <= '0;
            end
         end
      end

      assign w_filt[gi] = r_level;
   end

   logic w_scl_rise, w_scl_fall, w_scl_stable_hi, w_start, w_stop, w_both_hi;

   assign w_scl_rise      = w_filt[0] & ~r_filt_d[0];
   assign w_scl_fall      = ~w_filt[0] & r_filt_d[0];
   // An SCL transition in the same cycle masks any SDA condition.
   assign w_scl_stable_hi = w_filt[0] & r_filt_d[0];
   assign w_start         = w_scl_stable_hi & r_filt_d[1] & ~w_filt[1];
   assign w_stop          = w_scl_stable_hi & ~r_filt_d[1] & w_filt[1];
   assign w_both_hi       = w_filt[0] & w_filt[1];

   state_t         r_state, w_state_next;
   logic [BCW-1:0] r_free_cnt;
   logic           w_free_done;
   logic           w_to_done;
   logic           w_start_nx, w_rstart_nx, w_stop_nx;
   logic           r_scl_rise, r_scl_fall, r_start, r_rstart, r_stop, r_busy;

   assign w_free_done = w_both_hi & (r_free_cnt >= BCW'(BUS_FREE_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_free_cnt <= '0;
      end else if (r_state == IDLE || !w_both_hi) begin
         r_free_cnt <= '0;
      end else if (r_free_cnt != BCW'(BUS_FREE_CYCLES)) begin
         r_free_cnt <= r_free_cnt + BCW'(1);
      end
   end

`ifdef I2C_TIMEOUT_EN
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TCW-1:0] r_to_cnt;
   logic           r_timeout;

   assign w_to_done = (r_state == BUSY) & ~w_filt[0] & (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_to_done;
         if (r_state != BUSY || w_filt[0] || w_to_done) begin
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + TCW'(1);
         end
      end
   end

   assign timeout_o = r_timeout;
`else
   assign w_to_done = 1'b0;
   assign timeout_o = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_start_nx   = 1'b0;
      w_rstart_nx  = 1'b0;
      w_stop_nx    = 1'b0;
      case (r_state)
         UNSYNC: begin
            if (w_free_done) w_state_next = IDLE;
         end
         IDLE: begin
            if (w_start) begin
               w_state_next = BUSY;
               w_start_nx   = 1'b1;
            end else if (w_stop) begin
               w_stop_nx = 1'b1;
            end
         end
         BUSY: begin
            if (w_start) begin
               w_start_nx  = 1'b1;
               w_rstart_nx = 1'b1;
            end else if (w_stop) begin
               w_stop_nx    = 1'b1;
               w_state_next = FREE_WAIT;
            end
         end
         FREE_WAIT: begin
            if (w_start) begin
               w_state_next = BUSY;
               w_start_nx   = 1'b1;
            end else if (w_free_done) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = UNSYNC;
      endcase
      // A stuck-low SCL abandons the transfer and forces a resync.
      if (w_to_done) begin
         w_state_next = UNSYNC;
         w_start_nx   = 1'b0;
         w_rstart_nx  = 1'b0;
         w_stop_nx    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= UNSYNC;
         r_filt_d   <= 2'b00;
         r_scl_rise <= 1'b0;
         r_scl_fall <= 1'b0;
         r_start    <= 1'b0;
         r_rstart   <= 1'b0;
         r_stop     <= 1'b0;
         r_busy     <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_filt_d   <= w_filt;
         r_scl_rise <= w_scl_rise & (r_state != UNSYNC);
         r_scl_fall <= w_scl_fall & (r_state != UNSYNC);
         r_start    <= w_start_nx;
         r_rstart   <= w_rstart_nx;
         r_stop     <= w_stop_nx;
         r_busy     <= (w_state_next != IDLE);
      end
   end

   assign scl_o      = w_filt[0];
   assign sda_o      = w_filt[1];
   assign scl_rise_o = r_scl_rise;
   assign scl_fall_o = r_scl_fall;
   assign start_o    = r_start;
   assign rstart_o   = r_rstart;
   assign stop_o     = r_stop;
   assign bus_busy_o = r_busy;

endmodule

// File: doc/i2c_bus_frontend.md
Name: i2c_bus_frontend

Overview:
Input conditioning stage that sits directly upstream of the I2C slave core. It synchronises the raw SCL/SDA pins, glitch-filters them, and produces clean line levels plus single-cycle event strobes: SCL edges, START, repeated START, STOP and bus timeout. It also tracks bus ownership (busy/free), so the slave core never sees metastable or glitchy pin values.

Parameters:
SYNC_STAGES, 2, synchroniser flops per line; legal range 2..4.
FILT_LEN, 3, consecutive agreeing synchronised samples needed to change a filtered level; legal range 1..15.
BUS_FREE_CYCLES, 8, cycles both filtered lines must be high before the bus counts as free; legal range 1..65535.
TIMEOUT_CYCLES, 4096, SCL-low cycles in BUSY before a timeout; used only with the optional feature.

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
scl_i  input  1  raw SCL pin
sda_i  input  1  raw SDA pin
scl_o  output  1  filtered SCL level
sda_o  output  1  filtered SDA level
scl_rise_o  output  1  1-cycle strobe, filtered SCL 0->1
scl_fall_o  output  1  1-cycle strobe, filtered SCL 1->0
start_o  output  1  1-cycle strobe, START or repeated START
rstart_o  output  1  1-cycle strobe, repeated START only (coincides with start_o)
stop_o  output  1  1-cycle strobe, STOP
bus_busy_o  output  1  high while the bus is not known free
timeout_o  output  1  1-cycle strobe, SCL-low timeout

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - Synchroniser flops, filtered levels and filter counters: 0.
  - All strobes: 0. bus_busy_o: 1.
  - State: UNSYNC. Free counter and timeout counter: 0.
- Synchroniser: SYNC_STAGES flops per line; no logic between stages.
- Filter, per line:
  - The counter increments while the synchronised value differs from the filtered level.
  - The counter clears to 0 whenever the two agree.
  - When the count reaches FILT_LEN, the filtered level flips and the counter clears.
  - Counter width is clog2(FILT_LEN+1).
- Latency and strobes:
  - A filtered level changes SYNC_STAGES+FILT_LEN cycles after the first clock edge that samples the new pin value.
  - All strobes are registered and assert 1 cycle after the filtered change. Default total: 6 cycles.
  - A pin glitch shorter than FILT_LEN cycles produces no output change.
- Condition decode, on filtered values:
  - START = SDA 1->0 while SCL is stable high.
  - STOP = SDA 0->1 while SCL is stable high.
  - If SCL and SDA change in the same cycle, no START/STOP is decoded; only SCL edge strobes are issued.
- FSM states: UNSYNC, IDLE, BUSY, FREE_WAIT.
- UNSYNC:
  - The free counter counts cycles with both filtered lines high and clears when either line is low.
  - At BUS_FREE_CYCLES -> IDLE.
  - All strobes except timeout_o are suppressed.
- IDLE:
  - START -> BUSY, with start_o.
  - STOP -> stop_o, stay in IDLE.
- BUSY:
  - START -> start_o + rstart_o, stay in BUSY.
  - STOP -> stop_o, go to FREE_WAIT.
- FREE_WAIT:
  - Same counting rule as UNSYNC, then -> IDLE.
  - START -> BUSY with start_o only (no rstart_o); the counter clears.
- bus_busy_o = 0 only in IDLE. It is registered from the state, so it drops in the cycle the FSM enters IDLE.
- SCL edge strobes are issued in all states except UNSYNC.
- Reset mid-transfer: everything returns to its reset value immediately, and state returns to UNSYNC. No false START is issued when the pins come out of reset low.

Optional Feature:
Macro I2C_TIMEOUT_EN.
- Defined:
  - In BUSY, a counter of width clog2(TIMEOUT_CYCLES+1) counts cycles with filtered SCL low; it clears when SCL is high or when the state is not BUSY.
  - On reaching TIMEOUT_CYCLES: timeout_o strobes for 1 cycle, the FSM goes to UNSYNC and the counter clears. bus_busy_o stays 1.
- Not defined: timeout_o is tied to 0 and no counter logic exists. The port remains present.

Test Plan:
- Reset release with scl_i=sda_i=1 (defaults) -> bus_busy_o stays 1 for 2+3+8 cycles, then 0. No strobes are seen.
- From IDLE, drive sda_i 1->0 with scl_i=1 -> start_o=1 exactly 6 cycles later and bus_busy_o stays 1. Then a 2-cycle SDA glitch -> no change on sda_o.
- In BUSY, SCL low; SDA high; SCL high; SDA low -> start_o=rstart_o=1 for one cycle. SDA 0->1 with SCL high -> stop_o=1, and bus_busy_o=0 eight cycles after the filtered lines are both high.
- Drive scl_i and sda_i 1->0 in the same cycle -> scl_fall_o=1, start_o=0.
- Pulse rst_ni low for 1 cycle mid-BUSY while sda_i=0 and scl_i=1 -> start_o never asserts. bus_busy_o stays 1 until both pins have been high for 2+3+8 cycles.
- With I2C_TIMEOUT_EN and TIMEOUT_CYCLES=64: in BUSY, hold scl_i=0 -> timeout_o is a single 1-cycle strobe, 64 cycles after scl_o falls, and the FSM goes to UNSYNC. Without the macro -> timeout_o is constantly 0.
